// File: rtl/testdrive_interrupt_scheduler_if.sv
// Host-facing bundle of the interrupt scheduler: source lines, configuration,
// acknowledge strobe and the single presented interrupt.
interface testdrive_interrupt_scheduler_if #(
  parameter int C_SOURCES = 8
);
  localparam int IDW = $clog2(C_SOURCES);

  logic                 EN;
  logic [C_SOURCES-1:0] SRC_INTR;
  logic [C_SOURCES-1:0] SRC_EN;
  logic [C_SOURCES-1:0] SRC_EDGE;
  logic                 ACK;
  logic [IDW-1:0]       ACK_ID;
  logic                 INTR;
  logic [IDW-1:0]       INTR_ID;
  logic [C_SOURCES-1:0] PENDING;
  logic                 BUSY;

  modport master (
    output EN, SRC_INTR, SRC_EN, SRC_EDGE, ACK, ACK_ID,
    input  INTR, INTR_ID, PENDING, BUSY
  );

  modport slave (
    input  EN, SRC_INTR, SRC_EN, SRC_EDGE, ACK, ACK_ID,
    output INTR, INTR_ID, PENDING, BUSY
  );
endinterface

// File: rtl/testdrive_interrupt_scheduler.sv
// Collects edge/level interrupt sources, arbitrates them round-robin and
// presents one at a time on INTR, with an ACK-by-ID and a post-ACK hold-off.
module testdrive_interrupt_scheduler #(
  parameter int C_SOURCES        = 8,
  parameter int C_HOLDOFF_CYCLES = 16,
  parameter int C_ACTIVE         = 1
) (
  input logic                            CLK,
  input logic                            RST,
  testdrive_interrupt_scheduler_if.slave bus
);

  localparam int             IDW       = $clog2(C_SOURCES);
  localparam int             CW        = (C_HOLDOFF_CYCLES > 0) ? $clog2(C_HOLDOFF_CYCLES + 1) : 1;
  localparam logic           ACT       = (C_ACTIVE != 0);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(C_SOURCES - 1);
  localparam logic [CW-1:0]  HOLD_LOAD = CW'(C_HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  state_t               state_reg;
  logic [C_SOURCES-1:0] prev_reg;
  logic [C_SOURCES-1:0] pending_reg;
  logic [C_SOURCES-1:0] pending_next;
  logic [IDW-1:0]       rr_ptr_reg;
  logic [IDW-1:0]       rr_ptr_next;
  logic [IDW-1:0]       intr_id_reg;
  logic [CW-1:0]        hold_cnt_reg;
  logic                 intr_reg;
  logic                 busy_reg;
  logic                 ack_accept;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;

  // An ACK only counts against the source currently presented.
  assign ack_accept = bus.EN && (state_reg == ASSERT) && bus.ACK && (bus.ACK_ID == intr_id_reg);

  generate
    for (genvar gi = 0; gi < C_SOURCES; gi++) begin : g_pending
      logic rise;
      logic clr;
      assign rise = bus.SRC_EN[gi] & bus.SRC_INTR[gi] & ~prev_reg[gi];
      assign clr  = ack_accept & (bus.ACK_ID == IDW'(gi));
      // Edge mode: a new edge beats a same-cycle ACK; masking always clears.
      assign pending_next[gi] = bus.SRC_EDGE[gi]
                              ? (bus.SRC_EN[gi] & (rise | (pending_reg[gi] & ~clr)))
                              : (bus.SRC_EN[gi] & bus.SRC_INTR[gi]);
    end
  endgenerate

  // First pending source at or after the pointer, wrapping at C_SOURCES.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = rr_ptr_reg;
    for (int k = 0; k < C_SOURCES; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= C_SOURCES) begin
        idx = idx - C_SOURCES;
      end
      if (!grant_valid && pending_reg[idx[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  assign rr_ptr_next = (intr_id_reg == LAST_ID) ? '0 : intr_id_reg + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      prev_reg     <= '0;
      pending_reg  <= '0;
      rr_ptr_reg   <= '0;
      intr_id_reg  <= '0;
      hold_cnt_reg <= '0;
      intr_reg     <= ~ACT;
      busy_reg     <= 1'b0;
    end else begin
      prev_reg    <= bus.SRC_INTR;
      pending_reg <= pending_next;
      if (!bus.EN) begin
        state_reg <= IDLE;
        intr_reg  <= ~ACT;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (grant_valid) begin
              intr_id_reg <= grant_id;
              intr_reg    <= ACT;
              busy_reg    <= 1'b1;
              state_reg   <= ASSERT;
            end
          end
          ASSERT: begin
            if (ack_accept) begin
              intr_reg     <= ~ACT;
              rr_ptr_reg   <= rr_ptr_next;
              hold_cnt_reg <= HOLD_LOAD;
              if (C_HOLDOFF_CYCLES == 0) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= HOLDOFF;
              end
            end
          end
          HOLDOFF: begin
            hold_cnt_reg <= hold_cnt_reg - 1'b1;
            if (hold_cnt_reg <= CW'(1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            intr_reg  <= ~ACT;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.INTR    = intr_reg;
  assign bus.INTR_ID = intr_id_reg;
  assign bus.PENDING = pending_reg;
  assign bus.BUSY    = busy_reg;

endmodule

// File: tb/tb_testdrive_interrupt_scheduler.sv
// Drives two scheduler instances (hold-off 16 active-high, hold-off 4 active-low)
// with shared stimulus and compares both against a cycle-level reference model.
module tb_testdrive_interrupt_scheduler;

  localparam int N = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_ASSERT = 1;
  localparam int PH_HOLD = 2;

  logic clk;
  logic rst;
  logic en;
  logic [N-1:0] src_intr;
  logic [N-1:0] src_en;
  logic [N-1:0] src_edge;
  logic ack;
  logic [2:0] ack_id;

  int n_compared = 0;
  int n_mismatch = 0;

  testdrive_interrupt_scheduler_if #(.C_SOURCES(N)) if_a ();
  testdrive_interrupt_scheduler_if #(.C_SOURCES(N)) if_b ();

  assign if_a.EN = en;       assign if_b.EN = en;
  assign if_a.SRC_INTR = src_intr; assign if_b.SRC_INTR = src_intr;
  assign if_a.SRC_EN = src_en;     assign if_b.SRC_EN = src_en;
  assign if_a.SRC_EDGE = src_edge; assign if_b.SRC_EDGE = src_edge;
  assign if_a.ACK = ack;     assign if_b.ACK = ack;
  assign if_a.ACK_ID = ack_id; assign if_b.ACK_ID = ack_id;

  testdrive_interrupt_scheduler #(.C_SOURCES(N), .C_HOLDOFF_CYCLES(16), .C_ACTIVE(1)) dut_a (
    .CLK(clk), .RST(rst), .bus(if_a)
  );
  testdrive_interrupt_scheduler #(.C_SOURCES(N), .C_HOLDOFF_CYCLES(4), .C_ACTIVE(0)) dut_b (
    .CLK(clk), .RST(rst), .bus(if_b)
  );

  logic [1:0] o_intr;
  logic [1:0] o_busy;
  logic [2:0] o_id [2];
  logic [N-1:0] o_pend [2];
  assign o_intr[0] = if_a.INTR;    assign o_intr[1] = if_b.INTR;
  assign o_busy[0] = if_a.BUSY;    assign o_busy[1] = if_b.BUSY;
  assign o_id[0] = if_a.INTR_ID;   assign o_id[1] = if_b.INTR_ID;
  assign o_pend[0] = if_a.PENDING; assign o_pend[1] = if_b.PENDING;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model state, one set per instance.
  logic [N-1:0] m_pend [2];
  logic [N-1:0] m_prev [2];
  int m_phase [2];
  int m_id [2];
  int m_ptr [2];
  int m_wait [2];

  function automatic int hold_of(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic logic act_of(input int d);
    return (d == 0);
  endfunction

  task automatic model_reset(input int d);
    m_pend[d] = '0; m_prev[d] = '0; m_phase[d] = PH_IDLE;
    m_id[d] = 0; m_ptr[d] = 0; m_wait[d] = 0;
  endtask

  task automatic model_step(input int d);
    logic [N-1:0] p;
    logic [N-1:0] np;
    bit accept;
    bit found;
    p = m_pend[d];
    accept = en && (m_phase[d] == PH_ASSERT) && ack && (int'(ack_id) == m_id[d]);
    for (int i = 0; i < N; i++) begin
      if (src_edge[i]) begin
        if (!src_en[i]) np[i] = 1'b0;
        else if (src_intr[i] && !m_prev[d][i]) np[i] = 1'b1;
        else if (accept && int'(ack_id) == i) np[i] = 1'b0;
        else np[i] = p[i];
      end else begin
        np[i] = src_en[i] & src_intr[i];
      end
    end
    if (!en) begin
      m_phase[d] = PH_IDLE;
    end else if (m_phase[d] == PH_IDLE) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && p[(m_ptr[d] + k) % N]) begin
          found = 1'b1;
          m_id[d] = (m_ptr[d] + k) % N;
        end
      end
      if (found) m_phase[d] = PH_ASSERT;
    end else if (m_phase[d] == PH_ASSERT) begin
      if (accept) begin
        m_ptr[d] = (m_id[d] + 1) % N;
        m_wait[d] = hold_of(d);
        m_phase[d] = (hold_of(d) == 0) ? PH_IDLE : PH_HOLD;
      end
    end else begin
      m_wait[d] = m_wait[d] - 1;
      if (m_wait[d] == 0) m_phase[d] = PH_IDLE;
    end
    m_pend[d] = np;
    m_prev[d] = src_intr;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] exp_pack(input int d);
    logic e_intr;
    e_intr = (m_phase[d] == PH_ASSERT) ? act_of(d) : ~act_of(d);
    return {e_intr, 3'(m_id[d]), m_pend[d], (m_phase[d] != PH_IDLE)};
  endfunction

  function automatic logic [12:0] act_pack(input int d);
    return {o_intr[d], o_id[d], o_pend[d], o_busy[d]};
  endfunction

  // One clock: the model consumes the same inputs the DUTs sampled.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else model_step(d);
    end
    #1;
    check("model_a", 32'(act_pack(0)), 32'(exp_pack(0)));
    check("model_b", 32'(act_pack(1)), 32'(exp_pack(1)));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic do_ack(input int id);
    ack = 1'b1; ack_id = 3'(id);
    tick();
    ack = 1'b0;
    $display("ack id=%0d", id);
  endtask

  task automatic wait_grant(input int d, input int exp_id, output int waited);
    waited = 0;
    while (o_intr[d] !== act_of(d) && waited < 60) begin
      tick();
      waited++;
    end
    check($sformatf("grant_active_dut%0d", d), 32'(o_intr[d]), 32'(act_of(d)));
    check($sformatf("grant_id_dut%0d", d), 32'(o_id[d]), 32'(exp_id));
    $display("grant dut%0d id=%0d after %0d cycles", d, o_id[d], waited);
  endtask

  typedef struct {
    logic [N-1:0] src;
    logic         ack;
    logic [2:0]   ack_id;
    logic         e_intr;
    logic [2:0]   e_id;
    logic [N-1:0] e_pend;
    logic         e_busy;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int w;
    int n;
    int seen;

    // Single edge source on instance A: pulse, grant, ACK, 16-cycle hold-off.
    tbl[0] = '{8'h01, 1'b0, 3'd0, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 3'd0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[2] = '{8'h00, 1'b0, 3'd0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1};
    for (int j = 4; j < 24; j++) begin
      tbl[j] = '{8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, (j <= 18)};
    end

    rst = 1'b1; en = 1'b0; src_intr = '0; src_en = '0; src_edge = '0;
    ack = 1'b0; ack_id = '0;
    for (int d = 0; d < 2; d++) model_reset(d);
    tick(); tick();
    check("rst_a", 32'(act_pack(0)), 32'({1'b0, 3'd0, 8'h00, 1'b0}));
    check("rst_b", 32'(act_pack(1)), 32'({1'b1, 3'd0, 8'h00, 1'b0}));
    rst = 1'b0;

    en = 1'b1; src_edge = 8'hFF; src_en = 8'h01;
    for (int j = 0; j < 24; j++) begin
      src_intr = tbl[j].src; ack = tbl[j].ack; ack_id = tbl[j].ack_id;
      tick();
      check($sformatf("vec%0d", j), 32'(act_pack(0)),
            32'({tbl[j].e_intr, tbl[j].e_id, tbl[j].e_pend, tbl[j].e_busy}));
    end
    ack = 1'b0;

    // Round-robin: 1, 3, 5 pending; re-pend 1 and 3 during ACK of 3.
    do_reset();
    src_en = 8'hFF; src_edge = 8'hFF;
    src_intr = 8'h2A; tick(); src_intr = 8'h00;
    wait_grant(0, 1, w); do_ack(1);
    wait_grant(0, 3, w);
    src_intr = 8'h0A; do_ack(3); src_intr = 8'h00;
    check("rr_repend", 32'(o_pend[0] & 8'h2A), 32'h2A);
    wait_grant(0, 5, w); do_ack(5);
    wait_grant(0, 1, w); do_ack(1);
    wait_grant(0, 3, w); do_ack(3);

    // Set/clear collision on source 4 (pointer now 4).
    src_intr = 8'h10; tick(); src_intr = 8'h00;
    wait_grant(0, 4, w);
    src_intr = 8'h10; do_ack(4); src_intr = 8'h00;
    check("collide_pend4", 32'(o_pend[0][4]), 32'd1);
    wait_grant(0, 4, w);
    check("collide_gap", 32'(w), 32'd17);
    do_ack(4);

    // Level source 2 on instance B (hold-off 4, active low).
    do_reset();
    src_edge = 8'hFB; src_en = 8'h04; src_intr = 8'h04;
    wait_grant(1, 2, w); do_ack(2);
    n = 0;
    while (o_busy[1] && n < 20) begin
      tick(); n++;
    end
    check("level_holdoff_len", 32'(n), 32'd4);
    check("level_idle_gap", 32'(o_intr[1]), 32'd1);
    tick();
    check("level_rearm", 32'({o_intr[1], o_id[1]}), 32'({1'b0, 3'd2}));
    do_ack(2);
    src_intr = 8'h00;
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (o_intr[1] == 1'b0) seen++;
    end
    check("level_dropped", 32'(seen), 32'd0);

    // Bad ACK ID and masking of pending source 7.
    do_reset();
    src_edge = 8'hFF; src_en = 8'hFF;
    src_intr = 8'h84; tick(); src_intr = 8'h00;
    wait_grant(0, 2, w);
    do_ack(6);
    check("bad_ack", 32'({o_intr[0], o_id[0]}), 32'({1'b1, 3'd2}));
    src_en = 8'h7F; tick();
    check("mask_pend7", 32'(o_pend[0][7]), 32'd0);
    do_ack(2);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (o_intr[0] == 1'b1) seen++;
    end
    check("mask_never", 32'(seen), 32'd0);

    // Reset while asserted, then EN gating.
    src_en = 8'hFF;
    src_intr = 8'h01; tick(); src_intr = 8'h00;
    wait_grant(0, 0, w);
    do_reset();
    check("rst_mid", 32'({o_intr[0], o_pend[0], o_busy[0]}), 32'({1'b0, 8'h00, 1'b0}));
    en = 1'b0;
    src_intr = 8'h08; tick(); src_intr = 8'h00;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_intr[0] == 1'b1) seen++;
    end
    check("en_off_quiet", 32'(seen), 32'd0);
    check("en_off_pend3", 32'(o_pend[0][3]), 32'd1);
    en = 1'b1; tick();
    check("en_on_grant", 32'({o_intr[0], o_id[0]}), 32'({1'b1, 3'd3}));

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 19) != 0);
      src_intr = src_intr ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) src_en = 8'($urandom);
      if ($urandom_range(0, 49) == 0) src_edge = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) ack_id = 3'($urandom_range(0, 7));
      else ack_id = 3'(m_id[$urandom_range(0, 1)]);
      tick();
    end
    rst = 1'b0; ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
